// File: rtl/weight_tile_fifo.sv
// Tile-granular weight FIFO between the weight loader and the array preload path.
// Rows go in one per cycle; whole tiles stream out row by row, optionally reversed.
module weight_tile_fifo #(
    parameter int WEIGHT_BW    = 8,
    parameter int MATRIX_SIZE  = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int AF_THRESH    = FIFO_DEPTH - 1,
    parameter bit REVERSE_ROWS = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 clear_i,
    input  logic                                 wr_valid_i,
    output logic                                 wr_ready_o,
    input  logic [WEIGHT_BW*MATRIX_SIZE-1:0]     wr_data_i,
    input  logic                                 rd_start_i,
    output logic                                 rd_valid_o,
    output logic [WEIGHT_BW*MATRIX_SIZE-1:0]     rd_data_o,
    output logic [$clog2(MATRIX_SIZE)-1:0]       rd_row_o,
    output logic                                 rd_last_o,
    output logic                                 rd_busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      tile_count_o,
    output logic                                 empty_o,
    output logic                                 full_o,
    output logic                                 almost_full_o,
    output logic                                 underflow_err_o
);

    localparam int DW = WEIGHT_BW * MATRIX_SIZE;
    localparam int RW = $clog2(MATRIX_SIZE);
    localparam int TW = $clog2(FIFO_DEPTH);
    localparam int PW = TW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH * MATRIX_SIZE);
    localparam int SLOTS = FIFO_DEPTH * MATRIX_SIZE;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic          uf_q, uf_d;

    logic [DW-1:0] mem_q [SLOTS];

    logic          empty, full;
    logic          wr_fire, wr_last, commit;
    logic          emit, last_row, free;
    logic [RW-1:0] phys_row;
    logic [AW-1:0] wr_addr, rd_addr;

    // Wrap bits distinguish a full ring from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[TW-1:0] == rd_ptr_q[TW-1:0])
                && (wr_ptr_q[TW] != rd_ptr_q[TW]);

    assign wr_fire = wr_valid_i && !full;
    assign wr_last = (wr_row_q == RW'(MATRIX_SIZE - 1));
    assign commit  = wr_fire && wr_last;

    assign phys_row = REVERSE_ROWS ? (RW'(MATRIX_SIZE - 1) - rd_cnt_q)
                                   : rd_cnt_q;

    assign wr_addr = AW'(wr_ptr_q[TW-1:0]) * AW'(MATRIX_SIZE)
                   + AW'(wr_row_q);
    assign rd_addr = AW'(rd_ptr_q[TW-1:0]) * AW'(MATRIX_SIZE)
                   + AW'(phys_row);

    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_start_i && !empty) begin
                    state_d  = S_STREAM;
                    rd_cnt_d = '0;
                end
            end
            S_STREAM: begin
                if (last_row) begin
                    rd_cnt_d = '0;
                    if (!(rd_start_i && (count_d != '0))) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + RW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        emit     = (state_q == S_STREAM);
        last_row = emit && (rd_cnt_q == RW'(MATRIX_SIZE - 1));
        free     = last_row;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_row_d = wr_row_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            if (wr_last) begin
                wr_row_d = '0;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_row_d = wr_row_q + RW'(1);
            end
        end
        if (free) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({commit, free})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_valid_d = emit;
        rd_last_d  = last_row;
        rd_data_d  = emit ? mem_q[rd_addr] : rd_data_q;
        rd_row_d   = emit ? phys_row : rd_row_q;
        uf_d       = uf_q || (rd_start_i && empty && (state_q == S_IDLE));
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_row_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_row_q   <= '0;
            uf_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_row_q   <= wr_row_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            rd_row_q   <= rd_row_d;
            uf_q       <= uf_d;
        end
    end

    // Row storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_addr] <= wr_data_i;
        end
    end

    assign wr_ready_o      = !full;
    assign rd_valid_o      = rd_valid_q;
    assign rd_data_o       = rd_data_q;
    assign rd_row_o        = rd_row_q;
    assign rd_last_o       = rd_last_q;
    assign rd_busy_o       = rd_valid_q;
    assign tile_count_o    = count_q;
    assign empty_o         = empty;
    assign full_o          = full;
    assign almost_full_o   = (count_q >= CW'(AF_THRESH));
    assign underflow_err_o = uf_q;

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Bench for weight_tile_fifo: forward and reversed instances on shared stimulus,
// vector table, directed corner sequences and a queue-based random model.
module tb_weight_tile_fifo;

    localparam int W  = 8;
    localparam int M  = 4;
    localparam int D  = 4;
    localparam int AF = D - 1;
    localparam int DW = W * M;

    typedef logic [M-1:0][DW-1:0] tile_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, clear, wr_valid, rd_start;
    logic [DW-1:0] wr_data;

    logic          f_ready, f_valid, f_last, f_busy;
    logic          f_empty, f_full, f_af, f_uf;
    logic [DW-1:0] f_data;
    logic [1:0]    f_row;
    logic [2:0]    f_count;

    logic          r_ready, r_valid, r_last, r_busy;
    logic          r_empty, r_full, r_af, r_uf;
    logic [DW-1:0] r_data;
    logic [1:0]    r_row;
    logic [2:0]    r_count;

    weight_tile_fifo #(
        .WEIGHT_BW(W), .MATRIX_SIZE(M), .FIFO_DEPTH(D),
        .AF_THRESH(AF), .REVERSE_ROWS(1'b0)
    ) u_fwd (
        .clk(clk), .rstn(rstn), .clear_i(clear),
        .wr_valid_i(wr_valid), .wr_ready_o(f_ready), .wr_data_i(wr_data),
        .rd_start_i(rd_start), .rd_valid_o(f_valid), .rd_data_o(f_data),
        .rd_row_o(f_row), .rd_last_o(f_last), .rd_busy_o(f_busy),
        .tile_count_o(f_count), .empty_o(f_empty), .full_o(f_full),
        .almost_full_o(f_af), .underflow_err_o(f_uf)
    );

    weight_tile_fifo #(
        .WEIGHT_BW(W), .MATRIX_SIZE(M), .FIFO_DEPTH(D),
        .AF_THRESH(AF), .REVERSE_ROWS(1'b1)
    ) u_rev (
        .clk(clk), .rstn(rstn), .clear_i(clear),
        .wr_valid_i(wr_valid), .wr_ready_o(r_ready), .wr_data_i(wr_data),
        .rd_start_i(rd_start), .rd_valid_o(r_valid), .rd_data_o(r_data),
        .rd_row_o(r_row), .rd_last_o(r_last), .rd_busy_o(r_busy),
        .tile_count_o(r_count), .empty_o(r_empty), .full_o(r_full),
        .almost_full_o(r_af), .underflow_err_o(r_uf)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input int cnt);
        chk({nm, ".count"}, 64'(f_count), 64'(cnt));
        chk({nm, ".empty"}, 64'(f_empty), 64'(cnt == 0));
        chk({nm, ".full"},  64'(f_full),  64'(cnt == D));
        chk({nm, ".af"},    64'(f_af),    64'(cnt >= AF));
        chk({nm, ".ready"}, 64'(f_ready), 64'(cnt < D));
        chk({nm, ".rcount"}, 64'(r_count), 64'(cnt));
    endtask

    typedef struct {
        logic rn, cl, wv, rs;
        logic [DW-1:0] wd;
        logic ev, el, ee, eu;
        int   er, ec;
    } vec_t;

    function automatic vec_t mk(bit rn, bit cl, bit wv, int wrow, bit rs,
                                bit ev, int er, bit el, int ec, bit ee,
                                bit eu);
        vec_t v;
        v.rn = rn; v.cl = cl; v.wv = wv; v.rs = rs;
        v.wd = DW'(wrow * 32'h01010101);
        v.ev = ev; v.er = er; v.el = el; v.ec = ec; v.ee = ee; v.eu = eu;
        return v;
    endfunction

    vec_t tv[14];

    // Reference model state: committed-unstarted tiles, partial rows, live tile.
    tile_t         m_tiles[$];
    logic [DW-1:0] m_part[$];
    tile_t         m_cur;
    int            m_left, m_cnt;
    bit            m_uf;

    initial begin
        tile_t t0, t1, tc, tn;
        tile_t tf[D];

        rstn = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;
        wr_data = '0;

        tv[0]  = mk(0,0,0,0,0, 0,0,0,0,1,0);
        tv[1]  = mk(1,0,1,1,0, 0,0,0,0,1,0);
        tv[2]  = mk(1,0,1,2,0, 0,0,0,0,1,0);
        tv[3]  = mk(1,0,1,3,0, 0,0,0,0,1,0);
        tv[4]  = mk(1,0,1,4,0, 0,0,0,1,0,0);
        tv[5]  = mk(1,0,0,0,1, 0,0,0,1,0,0);
        tv[6]  = mk(1,0,0,0,0, 1,0,0,1,0,0);
        tv[7]  = mk(1,0,0,0,0, 1,1,0,1,0,0);
        tv[8]  = mk(1,0,0,0,0, 1,2,0,1,0,0);
        tv[9]  = mk(1,0,0,0,0, 1,3,1,0,1,0);
        tv[10] = mk(1,0,0,0,0, 0,0,0,0,1,0);
        tv[11] = mk(1,0,0,0,1, 0,0,0,0,1,1);
        tv[12] = mk(1,0,0,0,0, 0,0,0,0,1,1);
        tv[13] = mk(1,1,0,0,0, 0,0,0,0,1,0);

        for (int i = 0; i < 14; i++) begin
            rstn = tv[i].rn; clear = tv[i].cl;
            wr_valid = tv[i].wv; wr_data = tv[i].wd;
            rd_start = tv[i].rs;
            tick();
            chk($sformatf("v%0d.valid", i), 64'(f_valid), 64'(tv[i].ev));
            chk($sformatf("v%0d.busy", i),  64'(f_busy),  64'(tv[i].ev));
            chk($sformatf("v%0d.last", i),  64'(f_last),  64'(tv[i].el));
            chk($sformatf("v%0d.uf", i),    64'(f_uf),    64'(tv[i].eu));
            chk($sformatf("v%0d.rvalid", i), 64'(r_valid), 64'(tv[i].ev));
            chk_flags($sformatf("v%0d", i), tv[i].ec);
            if (i == 0) begin
                chk("v0.rst_data", 64'(f_data), 64'(0));
                chk("v0.rst_row",  64'(f_row),  64'(0));
            end
            if (tv[i].ev) begin
                chk($sformatf("v%0d.data", i), 64'(f_data),
                    64'(DW'((tv[i].er + 1) * 32'h01010101)));
                chk($sformatf("v%0d.row", i), 64'(f_row), 64'(tv[i].er));
                chk($sformatf("v%0d.rdata", i), 64'(r_data),
                    64'(DW'((M - tv[i].er) * 32'h01010101)));
                chk($sformatf("v%0d.rrow", i), 64'(r_row),
                    64'(M - 1 - tv[i].er));
            end
        end
        rstn = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;

        // Commit of the next tile lands on the free edge of the current one.
        for (int r = 0; r < M; r++) begin
            t0[r] = DW'($urandom); t1[r] = DW'($urandom);
        end
        for (int r = 0; r < M; r++) begin
            wr_valid = 1'b1; wr_data = t0[r]; tick();
        end
        wr_valid = 1'b0;
        chk_flags("ov.pre", 1);
        rd_start = 1'b1; tick();
        chk("ov.acc_valid", 64'(f_valid), 64'(0));
        for (int r = 0; r < M; r++) begin
            wr_valid = 1'b1; wr_data = t1[r]; rd_start = (r == M - 1);
            tick();
            chk($sformatf("ov.a%0d.valid", r), 64'(f_valid), 64'(1));
            chk($sformatf("ov.a%0d.data", r), 64'(f_data), 64'(t0[r]));
            chk($sformatf("ov.a%0d.rdata", r), 64'(r_data),
                64'(t0[M-1-r]));
            chk($sformatf("ov.a%0d.last", r), 64'(f_last),
                64'(r == M - 1));
            chk_flags($sformatf("ov.a%0d", r), 1);
        end
        wr_valid = 1'b0; rd_start = 1'b0;
        for (int r = 0; r < M; r++) begin
            tick();
            chk($sformatf("ov.b%0d.valid", r), 64'(f_valid), 64'(1));
            chk($sformatf("ov.b%0d.data", r), 64'(f_data), 64'(t1[r]));
            chk($sformatf("ov.b%0d.rdata", r), 64'(r_data),
                64'(t1[M-1-r]));
            chk_flags($sformatf("ov.b%0d", r), (r == M - 1) ? 0 : 1);
        end
        tick();
        chk("ov.end_valid", 64'(f_valid), 64'(0));

        // Fill to capacity, hold off a fifth tile, drain across the wrap.
        for (int k = 0; k < D * M; k++) begin
            tf[k / M][k % M] = DW'($urandom);
            wr_valid = 1'b1; wr_data = tf[k / M][k % M];
            tick();
            if (k == 3 * M - 1) chk_flags("full.af", 3);
        end
        chk_flags("full.4", 4);
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_data = DW'(32'hDEADBEEF); tick();
        end
        chk_flags("full.hold", 4);
        wr_valid = 1'b0;
        rd_start = 1'b1; tick();
        for (int k = 0; k < D * M; k++) begin
            tick();
            chk($sformatf("drain%0d.valid", k), 64'(f_valid), 64'(1));
            chk($sformatf("drain%0d.data", k), 64'(f_data),
                64'(tf[k / M][k % M]));
            chk($sformatf("drain%0d.rdata", k), 64'(r_data),
                64'(tf[k / M][M - 1 - k % M]));
            chk($sformatf("drain%0d.last", k), 64'(f_last),
                64'(k % M == M - 1));
            if (k == M - 1) chk_flags("drain.free1", 3);
        end
        rd_start = 1'b0;
        tick();
        chk("drain.end_valid", 64'(f_valid), 64'(0));
        chk_flags("drain.end", 0);

        // Clear while a tile streams and a partial tile is pending.
        for (int r = 0; r < M; r++) begin
            tc[r] = DW'($urandom); tn[r] = DW'($urandom);
        end
        for (int r = 0; r < M + 2; r++) begin
            wr_valid = 1'b1; wr_data = (r < M) ? tc[r] : DW'($urandom);
            tick();
        end
        wr_valid = 1'b0; rd_start = 1'b1; tick();
        rd_start = 1'b0; tick(); tick();
        chk("clr.mid_valid", 64'(f_valid), 64'(1));
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr.valid", 64'(f_valid), 64'(0));
        chk("clr.busy",  64'(f_busy),  64'(0));
        chk_flags("clr", 0);
        for (int r = 0; r < M; r++) begin
            wr_valid = 1'b1; wr_data = tn[r]; tick();
            if (r == 1) chk_flags("clr.partial", 0);
        end
        wr_valid = 1'b0;
        chk_flags("clr.fresh", 1);
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        for (int r = 0; r < M; r++) begin
            tick();
            chk($sformatf("clr.r%0d.data", r), 64'(f_data), 64'(tn[r]));
            chk($sformatf("clr.r%0d.row", r), 64'(f_row), 64'(r));
            chk($sformatf("clr.r%0d.rrow", r), 64'(r_row), 64'(M - 1 - r));
        end
        tick();

        // Randomized traffic against the queue model.
        clear = 1'b1; tick(); clear = 1'b0;
        m_tiles.delete(); m_part.delete();
        m_left = 0; m_cnt = 0; m_uf = 1'b0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            bit idle, lastrow, ev, el, wr_ok, commit, free;
            int pre, er;
            logic [DW-1:0] edf, edr;
            tile_t t;
            wr_valid = ($urandom_range(0, 99) < 65);
            rd_start = ($urandom_range(0, 99) < 35);
            clear    = ($urandom_range(0, 299) == 0);
            wr_data  = DW'($urandom);
            ev = 1'b0; el = 1'b0; er = 0; edf = '0; edr = '0;
            if (clear) begin
                m_tiles.delete(); m_part.delete();
                m_left = 0; m_cnt = 0; m_uf = 1'b0;
            end else begin
                idle = (m_left == 0);
                lastrow = (m_left == 1);
                pre = m_cnt;
                if (!idle) begin
                    er = M - m_left;
                    ev = 1'b1; el = lastrow;
                    edf = m_cur[er]; edr = m_cur[M - 1 - er];
                    m_left--;
                end
                free = lastrow;
                wr_ok = wr_valid && (pre < D);
                commit = wr_ok && (m_part.size() == M - 1);
                if (wr_ok) m_part.push_back(wr_data);
                if (commit) begin
                    for (int i = 0; i < M; i++) t[i] = m_part[i];
                    m_tiles.push_back(t);
                    m_part.delete();
                end
                m_cnt = pre + int'(commit) - int'(free);
                if (rd_start && ((idle && pre > 0) || (lastrow && m_cnt > 0)))
                begin
                    m_cur = m_tiles.pop_front();
                    m_left = M;
                end
                if (rd_start && idle && pre == 0) m_uf = 1'b1;
            end
            tick();
            chk($sformatf("rnd%0d.valid", cyc), 64'(f_valid), 64'(ev));
            chk($sformatf("rnd%0d.busy", cyc), 64'(f_busy), 64'(ev));
            chk($sformatf("rnd%0d.last", cyc), 64'(f_last), 64'(el));
            chk($sformatf("rnd%0d.uf", cyc), 64'(f_uf), 64'(m_uf));
            chk_flags($sformatf("rnd%0d", cyc), m_cnt);
            if (ev) begin
                chk($sformatf("rnd%0d.data", cyc), 64'(f_data), 64'(edf));
                chk($sformatf("rnd%0d.row", cyc), 64'(f_row), 64'(er));
                chk($sformatf("rnd%0d.rdata", cyc), 64'(r_data), 64'(edr));
                chk($sformatf("rnd%0d.rrow", cyc), 64'(r_row),
                    64'(M - 1 - er));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
